// File: rtl/int_exec_unit.sv
// Integer execution unit: 1-cycle ALU fed by the issue queue, results buffered in an in-order FIFO for the CDB.
// Optional multi-cycle MUL on opcode 111 (replacing SRL) is built when INT_EXEC_MUL_EN is defined.
module int_exec_unit #(
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 6,
  parameter int RES_DEPTH = 2
`ifdef INT_EXEC_MUL_EN
  ,
  parameter int MUL_LAT   = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issueque_ready,
  input  logic [DATA_W-1:0] issueque_rs_data,
  input  logic [DATA_W-1:0] issueque_rt_data,
  input  logic [TAG_W-1:0]  issueque_rd_tag,
  input  logic [2:0]        issueque_opcode,
  output logic              issueblk_done,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data
);

  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RES_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RES_DEPTH);

  logic                     r_vld_p1;
  logic signed [DATA_W-1:0] r_rs_p1;
  logic signed [DATA_W-1:0] r_rt_p1;
  logic [TAG_W-1:0]         r_tag_p1;
  logic [2:0]               r_op_p1;

  logic [TAG_W-1:0]  r_fifo_tag  [RES_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [RES_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_busy;
  logic              w_done;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W:0]    w_inflight;
  logic [DATA_W-1:0] w_alu;

  function automatic logic [DATA_W-1:0] alu_f(input logic [2:0] op,
                                              input logic signed [DATA_W-1:0] a,
                                              input logic signed [DATA_W-1:0] b);
    case (op)
      3'b000:  alu_f = a + b;
      3'b001:  alu_f = a - b;
      3'b010:  alu_f = a & b;
      3'b011:  alu_f = a | b;
      3'b100:  alu_f = a ^ b;
      3'b101:  alu_f = {{(DATA_W-1){1'b0}}, (a < b)};
      3'b110:  alu_f = a << b[4:0];
`ifdef INT_EXEC_MUL_EN
      default: alu_f = $unsigned(a) * $unsigned(b);
`else
      default: alu_f = $unsigned(a) >> b[4:0];
`endif
    endcase
  endfunction

  // Credits count the EX slot plus buffered results, so a push never finds the FIFO full.
  assign w_inflight    = {{CNT_W{1'b0}}, r_vld_p1} + {1'b0, r_count};
  assign w_done        = reset & issueque_ready & ~w_busy & (w_inflight < DEPTH_C);
  assign issueblk_done = w_done;
  assign w_alu         = alu_f(r_op_p1, r_rs_p1, r_rt_p1);

`ifdef INT_EXEC_MUL_EN
  localparam int MCNT_W = $clog2(MUL_LAT);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [MCNT_W-1:0] r_mcnt;
  logic [MCNT_W-1:0] w_mcnt_nxt;

  assign w_busy = (r_state == S_MUL);
  assign w_push = (r_state == S_MUL) ? (r_mcnt == MCNT_W'(1)) : r_vld_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_mcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mcnt  <= w_mcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mcnt_nxt  = r_mcnt;
    case (r_state)
      S_IDLE: begin
        if (w_done && issueque_opcode == 3'b111) begin
          w_state_nxt = S_MUL;
          w_mcnt_nxt  = MCNT_W'(MUL_LAT - 1);
        end
      end
      default: begin
        w_mcnt_nxt = r_mcnt - MCNT_W'(1);
        if (r_mcnt == MCNT_W'(1)) w_state_nxt = S_IDLE;
      end
    endcase
  end
`else
  assign w_busy = 1'b0;
  assign w_push = r_vld_p1;
`endif

  // p0 -> p1: capture the accepted instruction into the EX slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_vld_p1 <= 1'b0;
    else if (w_done) r_vld_p1 <= 1'b1;
    else if (w_push) r_vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_done) begin
      r_rs_p1  <= issueque_rs_data;
      r_rt_p1  <= issueque_rt_data;
      r_tag_p1 <= issueque_rd_tag;
      r_op_p1  <= issueque_opcode;
    end
  end

  // p1 -> p2: ALU result enters the result FIFO
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_tag[r_wr_ptr]  <= r_tag_p1;
      r_fifo_data[r_wr_ptr] <= w_alu;
    end
  end

  assign w_pop = cdb_grant & (r_count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is masked while empty so stale entries never reach the bus.
  assign cdb_req   = (r_count != '0);
  assign cdb_valid = cdb_req & cdb_grant;
  assign cdb_tag   = cdb_req ? r_fifo_tag[r_rd_ptr]  : '0;
  assign cdb_data  = cdb_req ? r_fifo_data[r_rd_ptr] : '0;

endmodule

// File: tb/tb_int_exec_unit.sv
// Directed scoreboard bench for int_exec_unit (default build, RES_DEPTH=2).
module tb_int_exec_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [5:0]  tag;
  logic [2:0]  op;
  logic        grant;
  logic        done;
  logic        req;
  logic        valid;
  logic [5:0]  ctag;
  logic [31:0] cdata;

  always #5 clk = ~clk;

  int_exec_unit #(.DATA_W(32), .TAG_W(6), .RES_DEPTH(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .issueque_ready   (ready),
    .issueque_rs_data (rs),
    .issueque_rt_data (rt),
    .issueque_rd_tag  (tag),
    .issueque_opcode  (op),
    .issueblk_done    (done),
    .cdb_req          (req),
    .cdb_grant        (grant),
    .cdb_valid        (valid),
    .cdb_tag          (ctag),
    .cdb_data         (cdata)
  );

  typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [5:0] tag; } op_t;
  typedef struct { logic [5:0] tag; logic [31:0] data; } res_t;

  op_t  pend[$];
  res_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n_done = 0;
  int   d0;
  logic        last_done, last_valid, last_req;
  logic [5:0]  last_tag;
  logic [31:0] last_data;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(input op_t o);
    case (o.op)
      3'd0:    return o.a + o.b;
      3'd1:    return o.a - o.b;
      3'd2:    return o.a & o.b;
      3'd3:    return o.a | o.b;
      3'd4:    return o.a ^ o.b;
      3'd5:    return ($signed(o.a) < $signed(o.b)) ? 32'd1 : 32'd0;
      3'd6:    return o.a << o.b[4:0];
      default: return o.a >> o.b[4:0];
    endcase
  endfunction

  function automatic op_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [5:0] t);
    op_t r;
    r.op = o; r.a = a; r.b = b; r.tag = t;
    return r;
  endfunction

  // One clock: drive queue head, check outputs mid-cycle, update scoreboard, advance.
  task automatic cycle();
    res_t e;
    logic exp_done;
    if (pend.size() > 0) begin
      ready = 1'b1; op = pend[0].op; rs = pend[0].a; rt = pend[0].b; tag = pend[0].tag;
    end else begin
      ready = 1'b0;
    end
    #1;
    exp_done = (pend.size() > 0) && (sb.size() < 2);
    chk("done", done, exp_done);
    chk("valid_eq", valid, req & grant);
    last_done = done; last_valid = valid; last_req = req; last_tag = ctag; last_data = cdata;
    if (valid) begin
      if (sb.size() == 0) chk("spurious_cdb", valid, 1'b0);
      else begin
        e = sb.pop_front();
        chk("cdb_tag", ctag, e.tag);
        chk("cdb_data", cdata, e.data);
      end
    end else if (req) begin
      if (sb.size() > 0) chk("held_tag", ctag, sb[0].tag);
      else chk("req_empty", req, 1'b0);
    end
    if (done && pend.size() > 0) begin
      e.tag = pend[0].tag; e.data = model(pend[0]);
      sb.push_back(e);
      void'(pend.pop_front());
      n_done++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (pend.size() == 0 && sb.size() == 0) break;
      cycle();
    end
    chk(name, 64'(pend.size() + sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ready = 1'b0; grant = 1'b0; rs = '0; rt = '0; tag = '0; op = '0;
    #1 reset = 1'b0;
    ready = 1'b1;
    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_tag", ctag, 6'd0);
    chk("rst_data", cdata, 32'd0);
    ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    // ADD latency and value
    grant = 1'b1;
    pend.push_back(mk(3'd0, 32'h11111111, 32'h11111111, 6'd10));
    cycle(); chk("add_accept", last_done, 1'b1);
    cycle(); chk("add_lat1", last_valid, 1'b0);
    cycle(); chk("add_lat2", last_valid, 1'b1);
    chk("add_tag", last_tag, 6'd10);
    chk("add_data", last_data, 32'h22222222);

    pend.push_back(mk(3'd1, 32'h00000000, 32'h00000001, 6'd11));
    pend.push_back(mk(3'd5, 32'hFFFFFFFF, 32'h00000001, 6'd12));
    drain("drain_sub_slt", 20);

    for (int i = 0; i < 8; i++)
      pend.push_back(mk(3'(i), $urandom, $urandom, 6'(20 + i)));
    drain("drain_allops", 60);

    // Back-pressure: credit limit allows only two accepts
    grant = 1'b0;
    pend.push_back(mk(3'd0, 32'd1, 32'd0, 6'd1));
    pend.push_back(mk(3'd0, 32'd2, 32'd0, 6'd2));
    pend.push_back(mk(3'd0, 32'd3, 32'd0, 6'd3));
    d0 = n_done;
    repeat (6) cycle();
    chk("bp_dones", 64'(n_done - d0), 64'd2);
    chk("bp_req", last_req, 1'b1);
    chk("bp_tag", last_tag, 6'd1);
    grant = 1'b1;
    drain("drain_bp", 30);

    // Continuous flow with pointer wrap and same-cycle push/pop
    for (int i = 0; i < 6; i++)
      pend.push_back(mk(3'(i % 5), $urandom, $urandom, 6'(40 + i)));
    drain("drain_flow", 60);

    // Reset with two results buffered
    grant = 1'b0;
    pend.push_back(mk(3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 6'd50));
    pend.push_back(mk(3'd3, 32'h0000000F, 32'h000000F0, 6'd51));
    repeat (4) cycle();
    chk("pre_rst_req", last_req, 1'b1);
    ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("mid_rst_req", req, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_tag", ctag, 6'd0);
    sb.delete();
    pend.delete();
    ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    grant = 1'b1;
    repeat (4) cycle();
    chk("post_rst_req", last_req, 1'b0);
    pend.push_back(mk(3'd6, 32'h00000001, 32'h0000001F, 6'd60));
    pend.push_back(mk(3'd7, 32'h80000000, 32'h0000001F, 6'd61));
    drain("drain_post_rst", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
